// File: rtl/segasys1_prgdec_hs.sv
// System 1 program-ROM decryptor (type-1 table, type-2 swap+XOR, bypass) with
// download-time type detection, req/ack ROM handshake and a one-entry fetch cache.
module segasys1_prgdec_hs #(
  parameter int unsigned AW       = 15,
  parameter logic [24:0] T1_BASE  = 25'h58400,
  parameter logic [24:0] T2_BASE  = 25'h48000,
  parameter int unsigned DETECT_N = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_m1,
  input  logic [AW-1:0] cpu_ad,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dt,
  output logic          rom_req,
  output logic [AW-1:0] rom_ad,
  input  logic          rom_ack,
  input  logic [7:0]    rom_dt,
  input  logic          dl_wr,
  input  logic [24:0]   dl_ad,
  input  logic [7:0]    dl_dt,
  input  logic [1:0]    mode_force,
  output logic [1:0]    mode
);

  typedef enum logic [1:0] {IDLE, FETCH, DEC, ACK} state_t;

  logic [7:0] t1_ram [128];
  logic [7:0] xr_ram [128];
  logic [7:0] sw_ram [128];
  logic       t1_we, xr_we, sw_we;

  always_comb begin
    t1_we = dl_wr && (dl_ad >= T1_BASE) && (dl_ad <= T1_BASE + 25'd127);
    xr_we = dl_wr && (dl_ad >= T2_BASE) && (dl_ad <= T2_BASE + 25'd127);
    sw_we = dl_wr && (dl_ad >= T2_BASE + 25'd128) && (dl_ad <= T2_BASE + 25'd255);
  end

  always_ff @(posedge clk) begin
    if (t1_we) t1_ram[dl_ad[6:0]] <= dl_dt;
    if (xr_we) xr_ram[dl_ad[6:0]] <= dl_dt;
    if (sw_we) sw_ram[dl_ad[6:0]] <= dl_dt;
  end

  // Source bits for output bits (6,4,2,0), one octal digit each.
  function automatic logic [11:0] swap_map(input logic [7:0] s);
    case (s)
      8'd0:  return 12'o6420;  8'd1:  return 12'o4620;  8'd2:  return 12'o2460;
      8'd3:  return 12'o0426;  8'd4:  return 12'o6240;  8'd5:  return 12'o6024;
      8'd6:  return 12'o6402;  8'd7:  return 12'o2640;  8'd8:  return 12'o4260;
      8'd9:  return 12'o4602;  8'd10: return 12'o6042;  8'd11: return 12'o0642;
      8'd12: return 12'o4062;  8'd13: return 12'o0462;  8'd14: return 12'o6204;
      8'd15: return 12'o2604;  8'd16: return 12'o0624;  8'd17: return 12'o2064;
      8'd18: return 12'o0264;  8'd19: return 12'o4206;  8'd20: return 12'o2406;
      8'd21: return 12'o4026;  8'd22: return 12'o2046;  8'd23: return 12'o0246;
      default: return 12'o0000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     cnt0_q, cnt0_d, cnt2_q, cnt2_d;
  logic [1:0]      auto_mode, mode_prev_q;
  logic            inval, hit;
  logic            cpu_ack_q, cpu_ack_d, rom_req_q, rom_req_d;
  logic [7:0]      cpu_dt_q, cpu_dt_d, raw_q, raw_d;
  logic [AW-1:0]   rom_ad_q, rom_ad_d, ha_q, ha_d;
  logic            m1_q, m1_d, ok_q, ok_d, hv_q, hv_d, hm1_q, hm1_d;
  logic [7:0]      hb_q, hb_d;
  logic            f;
  logic [6:0]      t1_idx, t2_idx;
  logic [7:0]      swp, perm, dec;
  logic [11:0]     map;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt2_d = cnt2_q;
    if (dl_wr) begin
      if (dl_ad >= T1_BASE) begin
        cnt0_d = (dl_dt != 8'd0)  ? '0 : ((cnt0_q == '1) ? cnt0_q : cnt0_q + 16'd1);
        cnt2_d = (dl_dt >= 8'd24) ? '0 : ((cnt2_q == '1) ? cnt2_q : cnt2_q + 16'd1);
      end else begin
        cnt0_d = '0;
        cnt2_d = '0;
      end
    end
    if (32'(cnt0_q) >= DETECT_N)      auto_mode = 2'd0;
    else if (32'(cnt2_q) >= DETECT_N) auto_mode = 2'd2;
    else                              auto_mode = 2'd1;
    mode  = (mode_force == 2'd0) ? auto_mode : mode_force - 2'd1;
    inval = dl_wr || (mode != mode_prev_q);
  end

  always_comb begin
    f      = raw_q[7];
    t1_idx = {rom_ad_q[12], rom_ad_q[8], rom_ad_q[4], rom_ad_q[0], ~m1_q, raw_q[5] ^ f, raw_q[3] ^ f};
    t2_idx = {rom_ad_q[14], rom_ad_q[12], rom_ad_q[9], rom_ad_q[6], rom_ad_q[3], rom_ad_q[0], ~m1_q};
    swp    = sw_ram[t2_idx];
    map    = swap_map(swp);
    perm   = '0;
    if (swp < 8'd24)
      perm = {raw_q[7], raw_q[map[11:9]], raw_q[5], raw_q[map[8:6]],
              raw_q[3], raw_q[map[5:3]],  raw_q[1], raw_q[map[2:0]]};
    case (mode)
      2'd1:    dec = (raw_q & 8'h57) | (t1_ram[t1_idx] ^ {f, 1'b0, f, 1'b0, f, 3'b000});
      2'd2:    dec = perm ^ xr_ram[t2_idx];
      default: dec = raw_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cpu_ack_d = 1'b0;
    cpu_dt_d  = cpu_dt_q;
    rom_req_d = rom_req_q;
    rom_ad_d  = rom_ad_q;
    raw_d     = raw_q;
    m1_d      = m1_q;
    ok_d      = ok_q;
    hv_d      = hv_q;
    ha_d      = ha_q;
    hm1_d     = hm1_q;
    hb_d      = hb_q;
    hit       = hv_q && !inval && (hm1_q == cpu_m1) && (ha_q == cpu_ad);
    case (state_q)
      IDLE: if (cpu_req) begin
        if (hit) begin
          cpu_dt_d  = hb_q;
          cpu_ack_d = 1'b1;
          state_d   = ACK;
        end else begin
          rom_req_d = 1'b1;
          rom_ad_d  = cpu_ad;
          m1_d      = cpu_m1;
          ok_d      = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: if (rom_ack) begin
        raw_d     = rom_dt;
        rom_req_d = 1'b0;
        state_d   = DEC;
      end
      DEC: begin
        cpu_dt_d  = dec;
        cpu_ack_d = 1'b1;
        state_d   = ACK;
      end
      default: begin
        state_d = IDLE;
        if (ok_q) begin
          hv_d  = 1'b1;
          ha_d  = rom_ad_q;
          hm1_d = m1_q;
          hb_d  = cpu_dt_q;
          ok_d  = 1'b0;
        end
      end
    endcase
    // Any table write or mode change kills both the cache and an in-flight fill.
    if (inval) begin
      hv_d = 1'b0;
      ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt0_q      <= '0;
      cnt2_q      <= '0;
      mode_prev_q <= 2'd1;
      cpu_ack_q   <= 1'b0;
      cpu_dt_q    <= '0;
      rom_req_q   <= 1'b0;
      rom_ad_q    <= '0;
      raw_q       <= '0;
      m1_q        <= 1'b0;
      ok_q        <= 1'b0;
      hv_q        <= 1'b0;
      ha_q        <= '0;
      hm1_q       <= 1'b0;
      hb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt0_q      <= cnt0_d;
      cnt2_q      <= cnt2_d;
      mode_prev_q <= mode;
      cpu_ack_q   <= cpu_ack_d;
      cpu_dt_q    <= cpu_dt_d;
      rom_req_q   <= rom_req_d;
      rom_ad_q    <= rom_ad_d;
      raw_q       <= raw_d;
      m1_q        <= m1_d;
      ok_q        <= ok_d;
      hv_q        <= hv_d;
      ha_q        <= ha_d;
      hm1_q       <= hm1_d;
      hb_q        <= hb_d;
    end
  end

  assign cpu_ack = cpu_ack_q;
  assign cpu_dt  = cpu_dt_q;
  assign rom_req = rom_req_q;
  assign rom_ad  = rom_ad_q;

endmodule

// File: tb/tb_segasys1_prgdec_hs.sv
// Randomized bench for segasys1_prgdec_hs against a behavioural decrypt/cache model.
module tb_segasys1_prgdec_hs;

  localparam logic [24:0] T1B = 25'h58400;
  localparam logic [24:0] T2B = 25'h48000;

  logic        clk, rst_n;
  logic        cpu_req, cpu_m1, cpu_ack, rom_req, rom_ack, dl_wr;
  logic [14:0] cpu_ad, rom_ad;
  logic [7:0]  cpu_dt, rom_dt, dl_dt;
  logic [24:0] dl_ad;
  logic [1:0]  mode_force, mode;

  segasys1_prgdec_hs #(.AW(15), .T1_BASE(T1B), .T2_BASE(T2B), .DETECT_N(128)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_m1(cpu_m1), .cpu_ad(cpu_ad),
    .cpu_ack(cpu_ack), .cpu_dt(cpu_dt), .rom_req(rom_req), .rom_ad(rom_ad),
    .rom_ack(rom_ack), .rom_dt(rom_dt), .dl_wr(dl_wr), .dl_ad(dl_ad), .dl_dt(dl_dt),
    .mode_force(mode_force), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [7:0]  m_t1 [128];
  logic [7:0]  m_xr [128];
  logic [7:0]  m_sw [128];
  int unsigned c0, c2;
  bit          mv, mm1;
  logic [14:0] madr;
  logic [7:0]  mbyte;
  string perms [24] = '{"6420","4620","2460","0426","6240","6024","6402","2640",
                        "4260","4602","6042","0642","4062","0462","6204","2604",
                        "0624","2064","0264","4206","2406","4026","2046","0246"};

  function automatic logic [1:0] m_mode();
    if (mode_force != 2'd0) return mode_force - 2'd1;
    if (c0 >= 128) return 2'd0;
    if (c2 >= 128) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [1:0] md, input logic m1,
                                         input logic [14:0] a, input logic [7:0] d);
    int unsigned idx, s, src;
    logic [7:0] p;
    if (md == 2'd1) begin
      idx = 64*int'(a[12]) + 32*int'(a[8]) + 16*int'(a[4]) + 8*int'(a[0])
          + (m1 ? 0 : 4) + 2*int'(d[5] ^ d[7]) + int'(d[3] ^ d[7]);
      return (d & 8'h57) | (m_t1[idx] ^ (d[7] ? 8'hA8 : 8'h00));
    end else if (md == 2'd2) begin
      idx = 64*int'(a[14]) + 32*int'(a[12]) + 16*int'(a[9]) + 8*int'(a[6])
          + 4*int'(a[3]) + 2*int'(a[0]) + (m1 ? 0 : 1);
      s = m_sw[idx];
      p = 8'h00;
      if (s < 24) begin
        p = d & 8'hAA;
        for (int k = 0; k < 4; k++) begin
          src = int'(perms[s].getc(k)) - 48;
          p[6-2*k] = d[src];
        end
      end
      return p ^ m_xr[idx];
    end
    return d;
  endfunction

  task automatic m_dl(input logic [24:0] a, input logic [7:0] v);
    if (a >= T1B && a <= T1B + 127) m_t1[a - T1B] = v;
    if (a >= T2B && a <= T2B + 127) m_xr[a - T2B] = v;
    if (a >= T2B + 128 && a <= T2B + 255) m_sw[a - T2B - 128] = v;
    if (a >= T1B) begin
      c0 = (v != 0) ? 0 : ((c0 < 65535) ? c0 + 1 : c0);
      c2 = (v >= 24) ? 0 : ((c2 < 65535) ? c2 + 1 : c2);
    end else begin
      c0 = 0;
      c2 = 0;
    end
    mv = 1'b0;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] v);
    dl_wr = 1'b1; dl_ad = a; dl_dt = v;
    @(posedge clk); #1;
    dl_wr = 1'b0;
    m_dl(a, v);
  endtask

  task automatic set_mf(input logic [1:0] v);
    logic [1:0] old;
    old = m_mode();
    mode_force = v;
    if (m_mode() != old) mv = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [24:0] rand_tab_addr();
    case ($urandom_range(0, 2))
      0:       return T1B + 25'($urandom_range(0, 127));
      1:       return T2B + 25'($urandom_range(0, 127));
      default: return T2B + 25'd128 + 25'($urandom_range(0, 127));
    endcase
  endfunction

  // One CPU fetch, entered just after a clock edge with the DUT idle.
  task automatic run_fetch(input string tag, input logic m1, input logic [14:0] ad,
                           input int unsigned dly, input logic [7:0] rb, input bit mid_en,
                           input logic [24:0] mid_ad, input logic [7:0] mid_dt,
                           output logic [7:0] got, output int unsigned ack_c, output int unsigned rq_c);
    bit hit;
    logic [7:0] hit_byte, exp_dt;
    hit = mv && (mm1 == m1) && (madr == ad);
    hit_byte = mbyte;
    cpu_req = 1'b1; cpu_m1 = m1; cpu_ad = ad;
    got = '0; ack_c = 0; rq_c = 0;
    for (int unsigned c = 1; c <= 40 && ack_c == 0; c++) begin
      @(posedge clk); #1;
      dl_wr = 1'b0;
      if (c == 1 && mid_en) begin
        dl_wr = 1'b1; dl_ad = mid_ad; dl_dt = mid_dt;
        m_dl(mid_ad, mid_dt);
      end
      if (rom_req) rq_c++;
      rom_ack = rom_req && (rq_c == dly);
      rom_dt  = rom_ack ? rb : 8'($urandom);
      if (cpu_ack) begin
        ack_c = c; got = cpu_dt; cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0; rom_ack = 1'b0;
    if (hit) exp_dt = hit_byte;
    else     exp_dt = ref_dec(m_mode(), m1, ad, rb);
    check({tag, "_dt"},  got,   exp_dt);
    check({tag, "_lat"}, ack_c, hit ? 1 : dly + 2);
    check({tag, "_rq"},  rq_c,  hit ? 0 : dly);
    check({tag, "_mode"}, mode, m_mode());
    if (!hit && !mid_en) begin
      mv = 1'b1; mm1 = m1; madr = ad; mbyte = exp_dt;
    end
    @(posedge clk); #1;
    dl_wr = 1'b0;
    check({tag, "_pulse"}, cpu_ack, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  logic [7:0]  got;
  int unsigned ack_c, rq_c;
  logic [14:0] pool [4];

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_m1 = 1'b0; cpu_ad = '0; rom_ack = 1'b0; rom_dt = '0;
    dl_wr = 1'b0; dl_ad = '0; dl_dt = '0; mode_force = 2'd0;
    c0 = 0; c2 = 0; mv = 1'b0; mm1 = 1'b0; madr = '0; mbyte = '0;
    for (int i = 0; i < 128; i++) begin m_t1[i] = '0; m_xr[i] = '0; m_sw[i] = '0; end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ack", cpu_ack, 1'b0);
    check("rst_dt", cpu_dt, 8'h00);
    check("rst_rreq", rom_req, 1'b0);
    check("rst_rad", rom_ad, 15'h0);
    check("rst_mode", mode, 2'd1);

    // Type 1
    for (int i = 0; i < 128; i++) dl_byte(T1B + 25'(i), 8'h00);
    set_mf(2'd2);
    run_fetch("t1", 1'b1, 15'h0, 2, 8'h80, 1'b0, '0, '0, got, ack_c, rq_c);
    check("t1_vec", got, 8'hA8);

    // Type 2
    dl_byte(T2B + 25'd128, 8'd1);
    dl_byte(T2B, 8'h01);
    set_mf(2'd3);
    run_fetch("t2", 1'b1, 15'h0, 1, 8'h40, 1'b0, '0, '0, got, ack_c, rq_c);
    check("t2_vec", got, 8'h11);
    dl_byte(T2B + 25'd128, 8'd30);
    run_fetch("t2z", 1'b1, 15'h0, 1, 8'h40, 1'b0, '0, '0, got, ack_c, rq_c);
    check("t2z_vec", got, 8'h01);

    // Latency, hit, invalidation
    set_mf(2'd1);
    run_fetch("lat", 1'b0, 15'h1234, 4, 8'h5A, 1'b0, '0, '0, got, ack_c, rq_c);
    check("lat_ack6", ack_c, 6);
    check("lat_rq4", rq_c, 4);
    run_fetch("hit", 1'b0, 15'h1234, 4, 8'hC3, 1'b0, '0, '0, got, ack_c, rq_c);
    check("hit_ack1", ack_c, 1);
    check("hit_rq0", rq_c, 0);
    check("hit_dt", got, 8'h5A);
    dl_byte(T2B + 25'd5, 8'h77);
    run_fetch("inv", 1'b0, 15'h1234, 4, 8'hC3, 1'b0, '0, '0, got, ack_c, rq_c);
    check("inv_rq4", rq_c, 4);
    check("inv_dt", got, 8'hC3);

    // Detection
    set_mf(2'd0);
    for (int i = 0; i < 128; i++) dl_byte(T1B + 25'(i), 8'h00);
    check("det_zero", mode, 2'd0);
    for (int i = 0; i < 128; i++) dl_byte(T1B + 25'(i), 8'h05);
    check("det_t2", mode, 2'd2);
    dl_byte(T1B, 8'h30);
    check("det_t1", mode, 2'd1);

    // Randomized traffic
    for (int i = 0; i < 128; i++) begin
      dl_byte(T1B + 25'(i), 8'($urandom));
      dl_byte(T2B + 25'(i), 8'($urandom));
      dl_byte(T2B + 25'd128 + 25'(i), 8'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 4; i++) pool[i] = 15'($urandom);
    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 10)      set_mf(2'($urandom_range(0, 3)));
      else if (r < 18) dl_byte(rand_tab_addr(), 8'($urandom_range(0, 40)));
      run_fetch("rnd", 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                $urandom_range(1, 5), 8'($urandom), ($urandom_range(0, 9) == 0),
                rand_tab_addr(), 8'($urandom), got, ack_c, rq_c);
    end

    // Reset during FETCH
    set_mf(2'd2);
    cpu_req = 1'b1; cpu_m1 = 1'b1; cpu_ad = 15'h0ABC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstf_pre", rom_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_rreq", rom_req, 1'b0);
    check("rstf_ack", cpu_ack, 1'b0);
    check("rstf_dt", cpu_dt, 8'h00);
    cpu_req = 1'b0; mode_force = 2'd0;
    c0 = 0; c2 = 0; mv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rom_ack = 1'b1; rom_dt = 8'h99;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rom_ack = 1'b0;
      check("stale_ack", cpu_ack, 1'b0);
      check("stale_rreq", rom_req, 1'b0);
    end
    check("rstf_mode", mode, 2'd1);
    set_mf(2'd1);
    run_fetch("post", 1'b1, 15'h0ABC, 2, 8'h3C, 1'b0, '0, '0, got, ack_c, rq_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segasys1_prgdec_hs.md
# segasys1_prgdec_hs

Handshaked, parametrised System 1 program-ROM decryptor that sits between the Z80 opcode/data fetch path and the program ROM controller. It decrypts type-1 (table substitution) and type-2 (bit-swap plus XOR) encryption, or bypasses it for plain ROMs. It auto-detects the type from the download stream, with an optional override. ROM latency is variable, handled by a req/ack handshake instead of a fixed two-phase clock. A one-entry last-fetch register answers repeated fetches without touching ROM.

## Interface
- AW, 15: CPU/ROM address width; must be ≥15.
- T1_BASE, 25'h58400: download address of the type-1 table (128 B); also the detection base.
- T2_BASE, 25'h48000: download address of the type-2 XOR table (128 B); swap table at T2_BASE+128.
- DETECT_N, 128: consecutive-byte threshold for type detection.

Ports:
- clk  in  1  system clock; everything, including download, is on this clock.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_req  in  1  fetch request; held high until cpu_ack.
- cpu_m1  in  1  opcode fetch (M1) qualifier.
- cpu_ad  in  AW  fetch address.
- cpu_ack  out  1  one-cycle pulse; cpu_dt is valid in that cycle.
- cpu_dt  out  8  decrypted byte; held until the next ack.
- rom_req  out  1  ROM read request; held until rom_ack.
- rom_ad  out  AW  ROM address; stable while rom_req is high.
- rom_ack  in  1  ROM data valid this cycle.
- rom_dt  in  8  raw ROM byte.
- dl_wr  in  1  download byte strobe.
- dl_ad  in  25  download address.
- dl_dt  in  8  download byte.
- mode_force  in  2  0 = auto, 1 = bypass, 2 = type1, 3 = type2.
- mode  out  2  effective mode: 0 = bypass, 1 = type1, 2 = type2.

## Operation
- Tables: three 128×8 RAMs (T1, XOR, SWP).
  - A dl_wr with dl_ad in [base, base+127] writes entry dl_ad[6:0].
  - RAM contents are not reset.
- Detection, on each dl_wr:
  - If dl_ad ≥ T1_BASE: cnt0 clears on a nonzero byte, else increments. cnt2 clears on a byte ≥24, else increments.
  - If dl_ad < T1_BASE: both counters clear.
  - Both counters are 16 bit and saturate.
  - Auto mode: 0 if cnt0 ≥ DETECT_N; else 2 if cnt2 ≥ DETECT_N; else 1. mode_force ≠ 0 overrides.
- Type 1, with d = raw byte and f = d[7]:
  - idx = {a12, a8, a4, a0, ~m1, d5^f, d3^f}.
  - out = (d & 8'h57) | (T1[idx] ^ {f,0,f,0,f,000}).
- Type 2:
  - ix = {a14, a12, a9, a6, a3, a0, ~m1}, s = SWP[ix].
  - Output bits 7, 5, 3, 1 pass through unchanged.
  - Bits (6,4,2,0) take the source bits listed per s: 0:6420 1:4620 2:2460 3:0426 4:6240 5:6024 6:6402 7:2640 8:4260 9:4602 10:6042 11:0642 12:4062 13:0462 14:6204 15:2604 16:0624 17:2064 18:0264 19:4206 20:2406 21:4026 22:2046 23:0246.
  - For s ≥ 24 the permuted byte is 0.
  - The result is then XORed with XOR[ix].
- Bypass: out = d.
- FSM states IDLE, FETCH, DEC, ACK:
  - IDLE, cpu_req with hit → ACK, using the cached byte.
  - IDLE, cpu_req without hit → FETCH. rom_req is set and rom_ad = cpu_ad.
  - FETCH waits for rom_ack, latches rom_dt, drops rom_req, then → DEC.
  - DEC does the synchronous table read and decode, then → ACK.
  - ACK pulses cpu_ack, then → IDLE.
- Hit register: {valid, m1, addr, byte}.
  - Loaded in ACK after a miss.
  - Hit = valid and {cpu_m1, cpu_ad} match.
  - Cleared by reset, by any dl_wr, and by any change of mode.
- A dl_wr during FETCH/DEC is legal. DEC uses the table contents present at the DEC edge, and the result is not cached.

## Timing
- Reset values: cpu_ack = 0, cpu_dt = 0, rom_req = 0, rom_ad = 0, mode = 1 (counters 0, mode_force = 0), state = IDLE, valid = 0.
- Miss, with cpu_req sampled at edge 0:
  - rom_req is high from cycle 1.
  - rom_ack is sampled at edge k ≥ 1.
  - cpu_ack is high in cycle k+2.
  - Latency is the same for all modes.
- Hit: cpu_ack is high in cycle 1.
- cpu_req must be low in the cycle after cpu_ack, or it starts a new request.
- rom_ack while rom_req is low is ignored.
- Reset asserted mid-fetch: immediate return to reset values. A stale rom_ack after release is ignored.

## Test plan
- Type 1: T1 all 0, mode_force = 2, m1 = 1, ad = 0, rom_dt = 8'h80 (idx 3) → cpu_dt = 8'hA8.
- Type 2: SWP[0] = 1, XOR[0] = 8'h01, mode_force = 3, m1 = 1, ad = 0, rom_dt = 8'h40 → cpu_dt = 8'h11. With SWP[0] = 30 → cpu_dt = 8'h01.
- Detection:
  - 128 zero bytes at T1_BASE → mode = 0.
  - 128 bytes of 8'h05 → mode = 2.
  - One byte 8'h30 after that → mode = 1.
- Latency and hit:
  - rom_ack delayed 4 cycles → cpu_ack at cycle 6, rom_req high exactly cycles 1–4.
  - An immediate repeat of the same address → cpu_ack at cycle 1, rom_req stays 0.
- Invalidation: a dl_wr between two identical fetches forces a ROM access on the second one.
- Reset: rst_n low during FETCH → rom_req and cpu_ack go 0 asynchronously. A rom_ack after release produces no cpu_ack.
